// File: rtl/multiword_add_seq.sv
// Word-serial wide adder/subtractor. One 32-bit Kogge-Stone prefix adder is
// reused every cycle; operands are walked LSW first and the carry is
// registered between slices. The result and final carry are published
// together on a one-cycle done pulse.

// 32-bit Kogge-Stone prefix adder with carry-in/carry-out.
module Prefix_adder32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [5:0][31:0] gl, pl;
  logic [32:0]      c;

  // Five prefix levels (span 1,2,4,8,16), then fold in the carry-in
  always_comb begin
    gl    = '0;
    pl    = '0;
    gl[0] = a & b;
    pl[0] = a ^ b;
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 32; i++) begin
        if (i >= (1 << l)) begin
          gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i-(1<<l)]);
          pl[l+1][i] = pl[l][i] & pl[l][i-(1<<l)];
        end else begin
          gl[l+1][i] = gl[l][i];
          pl[l+1][i] = pl[l][i];
        end
      end
    end
    c[0] = cin;
    for (int i = 0; i < 32; i++)
      c[i+1] = gl[5][i] | (pl[5][i] & cin);
    sum  = pl[0] ^ c[31:0];
    cout = c[32];
  end
endmodule

module multiword_add_seq #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [32*NWORDS-1:0] a_in,
  input  logic [32*NWORDS-1:0] b_in,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [32*NWORDS-1:0] sum_out,
  output logic                 cout
);
  localparam int W  = 32 * NWORDS;
  localparam int IW = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [W-1:0]   a_reg, b_reg, work;
  logic           carry_reg;
  logic [IW-1:0]  idx;

  logic [31:0]    add_sum;
  logic           add_co;
  logic [W-1:0]   final_res;
  logic           accept;

  // Single shared slice adder; the carry loop closes through carry_reg
  Prefix_adder32bit u_add (
    .a    (a_reg[idx*32 +: 32]),
    .b    (b_reg[idx*32 +: 32]),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_co)
  );

  // Full result on the last slice: top word comes straight from the adder
  always_comb begin
    final_res          = work;
    final_res[W-1 -: 32] = add_sum;
  end

  // New work is taken in IDLE and also in the DONE cycle (back-to-back)
  always_comb begin
    accept = start && (state == IDLE || state == DONE);
  end

  // Sequencer: latch operands, step slices, publish result with done
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      work      <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum_out   <= '0;
      cout      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: ;
        RUN: begin
          work[idx*32 +: 32] <= add_sum;
          carry_reg          <= add_co;
          idx                <= idx + 1'b1;
          if (idx == LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            sum_out <= final_res;
            cout    <= add_co;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (accept) begin
        state     <= RUN;
        busy      <= 1'b1;
        a_reg     <= a_in;
        b_reg     <= sub ? ~b_in : b_in;
        carry_reg <= sub ? 1'b1 : cin;
        idx       <= '0;
      end
    end
  end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq: the driver queues hand-computed
// results with the cycle they are due; a monitor checks every done pulse,
// busy length, result hold between completions and reset behaviour.
module tb_multiword_add_seq;
  localparam int NWORDS = 4;
  localparam int W      = 32 * NWORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum_out;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    int           due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;

  multiword_add_seq #(.NWORDS(NWORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
  );

  always #5 clk = ~clk;

  // Monitor: sample at the falling edge, compare against the queue
  initial begin : monitor
    logic [W-1:0] held;
    logic         hcout;
    logic         rst_last;
    int           bcnt;
    exp_t         e;
    held = '0; hcout = 1'b0; rst_last = 1'b1; bcnt = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst_last) begin
        held = '0; hcout = 1'b0; bcnt = 0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum_out !== '0 || cout !== 1'b0) begin
          errors++;
          $display("FAIL reset_outs: busy=%b done=%b cout=%b sum=%h, want all 0",
                   busy, done, cout, sum_out);
        end
      end else begin
        if (busy === 1'b1) bcnt++;
        if (done === 1'b1) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: cycle %0d sum=%h, no operation pending", ncyc, sum_out);
          end else begin
            e = q.pop_front();
            if (sum_out !== e.sum || cout !== e.co) begin
              errors++;
              $display("FAIL result: got sum=%h cout=%b, want sum=%h cout=%b",
                       sum_out, cout, e.sum, e.co);
            end
            checks++;
            if (ncyc != e.due) begin
              errors++;
              $display("FAIL done_latency: done at cycle %0d, want %0d", ncyc, e.due);
            end
            checks++;
            if (bcnt != NWORDS || busy !== 1'b0) begin
              errors++;
              $display("FAIL busy_len: busy cycles %0d busy_now=%b, want %0d and 0",
                       bcnt, busy, NWORDS);
            end
            held = e.sum; hcout = e.co;
          end
          bcnt = 0;
        end else begin
          checks++;
          if (sum_out !== held || cout !== hcout) begin
            errors++;
            $display("FAIL hold: cycle %0d sum=%h cout=%b, want sum=%h cout=%b",
                     ncyc, sum_out, cout, held, hcout);
          end
        end
      end
      rst_last = rst;
    end
  end

  // Drive one start pulse; optionally queue its expected result
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic ci, input bit push,
                       input logic [W-1:0] esum, input logic eco);
    exp_t e;
    @(posedge clk); #2;
    a_in = a; b_in = b; sub = s; cin = ci; start = 1'b1;
    if (push) begin
      e.sum = esum; e.co = eco; e.due = ncyc + 2 + NWORDS;
      q.push_back(e);
    end
    @(posedge clk); #2;
    start = 1'b0;
    a_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    b_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    sub  = 1'(($urandom() & 1));
    cin  = 1'(($urandom() & 1));
  endtask

  // Wait for all queued results, bounded
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin : stim
    // Reset held 2 cycles with start asserted
    rst = 1'b1; start = 1'b1; a_in = 128'h5; b_in = 128'h7;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
      end
    end

    // Full-width carry ripple
    issue(128'h1, {W{1'b1}}, 1'b0, 1'b0, 1'b1, 128'h0, 1'b1);
    drain();
    // Cross-word carry, cin 0 and 1
    issue(128'hD573235A, 128'h39A4BE05, 1'b0, 1'b0, 1'b1, 128'h1_0F17E15F, 1'b0);
    drain();
    issue(128'hD573235A, 128'h39A4BE05, 1'b0, 1'b1, 1'b1, 128'h1_0F17E160, 1'b0);
    drain();
    // Subtract with and without borrow; cin must be ignored
    issue(128'h5, 128'h7, 1'b1, 1'b0, 1'b1,
          128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0);
    drain();
    issue(128'h7, 128'h5, 1'b1, 1'b0, 1'b1, 128'h2, 1'b1);
    drain();

    // Start pulsed during RUN is ignored
    issue(128'h00000001_FFFFFFFF_FFFFFFFF_00000000,
          128'h00000000_00000000_00000001_00000000, 1'b0, 1'b0, 1'b1,
          128'h00000002_00000000_00000000_00000000, 1'b0);
    @(posedge clk); #2;
    a_in = 128'hAAAA; b_in = 128'h5555; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    drain();

    // Back-to-back: second start lands in the DONE cycle
    issue(128'h12345678_00000000_00000000_00000001,
          128'h11111111_00000000_00000000_00000002, 1'b0, 1'b0, 1'b1,
          128'h23456789_00000000_00000000_00000003, 1'b0);
    repeat (NWORDS - 1) @(posedge clk);
    issue(128'h30, 128'h10, 1'b1, 1'b0, 1'b1, 128'h20, 1'b1);
    drain();

    // Reset in the 2nd RUN cycle: no done, outputs cleared
    issue(128'h99, 128'h1, 1'b0, 1'b0, 1'b0, 128'h0, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    repeat (8) @(posedge clk);
    issue(128'h00000000_00000000_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0, 1'b1,
          128'h00000001_00000000_00000000, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
